// File: rtl/cond_flags_unit.sv
// cond_flags_unit: architectural NZCV flag register with per-bit write masks,
// banked save/restore slots, and a multi-lane ARM condition-code evaluator
// feeding a stallable result pipeline of configurable depth.
module cond_flags_unit #(
    parameter int LANES  = 2,
    parameter int NBANK  = 4,
    parameter int LAT    = 1,
    parameter int BYPASS = 1,
    localparam int IDXW  = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           flag_we,
    input  logic [3:0]           flag_wdata,
    input  logic                 save_en,
    input  logic [IDXW-1:0]      save_idx,
    input  logic                 restore_en,
    input  logic [IDXW-1:0]      restore_idx,
    input  logic [LANES-1:0]     in_valid,
    input  logic [4*LANES-1:0]   in_cond,
    input  logic                 stall,
    output logic [LANES-1:0]     out_valid,
    output logic [LANES-1:0]     out_pass,
    output logic [LANES-1:0]     out_nv,
    output logic [3:0]           flags
);

    // Every encodable slot index; indices past NBANK read back the live flags
    // so an out-of-range restore degenerates into "keep current flags".
    localparam int NSLOT = 1 << IDXW;

    logic [3:0] flags_q, flags_d;
    logic [3:0] bank_q [NBANK];
    logic [3:0] bank_d [NBANK];
    logic [3:0] slot_rd [NSLOT];
    logic [3:0] restore_base;
    logic [3:0] eval_flags;

    logic [LANES-1:0] lane_pass;
    logic [LANES-1:0] lane_nv;

    logic [LAT-1:0][LANES-1:0] vld_q,  vld_d;
    logic [LAT-1:0][LANES-1:0] pass_q, pass_d;
    logic [LAT-1:0][LANES-1:0] nv_q,   nv_d;

    // Condition-field truth function on {N,Z,C,V}; code F never passes.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = cf;
            4'h3:    cond_pass = !cf;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = cf & !z;
            4'h9:    cond_pass = !cf | z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z & (n == v);
            4'hD:    cond_pass = z | (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // Slot read mux: real banks below NBANK, live flags above.
    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < NBANK) begin : g_real
                assign slot_rd[gi] = bank_q[gi];
            end else begin : g_oob
                assign slot_rd[gi] = flags_q;
            end
        end
    endgenerate

    // Flag next-state: restore supplies the base, then masked writes override per bit.
    always_comb begin
        restore_base = restore_en ? slot_rd[restore_idx] : flags_q;
        flags_d      = (restore_base & ~flag_we) | (flag_wdata & flag_we);
        eval_flags   = (BYPASS != 0) ? flags_d : flags_q;
    end

    // Save captures the pre-update flags; out-of-range indices match no bank.
    always_comb begin
        for (int i = 0; i < NBANK; i++) begin
            bank_d[i] = (save_en && (save_idx == IDXW'(i))) ? flags_q : bank_q[i];
        end
    end

    // Per-lane evaluation; idle lanes report nothing.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [3:0] lane_cond;
            assign lane_cond     = in_cond[4*gi +: 4];
            assign lane_pass[gi] = in_valid[gi] & cond_pass(lane_cond, eval_flags);
            assign lane_nv[gi]   = in_valid[gi] & (lane_cond == 4'hF);
        end
    endgenerate

    // Result pipeline: hold everything on stall, otherwise capture and shift.
    always_comb begin
        vld_d  = vld_q;
        pass_d = pass_q;
        nv_d   = nv_q;
        if (!stall) begin
            vld_d[0]  = in_valid;
            pass_d[0] = lane_pass;
            nv_d[0]   = lane_nv;
            for (int s = 1; s < LAT; s++) begin
                vld_d[s]  = vld_q[s-1];
                pass_d[s] = pass_q[s-1];
                nv_d[s]   = nv_q[s-1];
            end
        end
    end

    // State registers; flag writeback and banks are never stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
            vld_q   <= '0;
            pass_q  <= '0;
            nv_q    <= '0;
            for (int i = 0; i < NBANK; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            flags_q <= flags_d;
            vld_q   <= vld_d;
            pass_q  <= pass_d;
            nv_q    <= nv_d;
            for (int i = 0; i < NBANK; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out_pass  = pass_q[LAT-1];
    assign out_nv    = nv_q[LAT-1];
    assign flags     = flags_q;

endmodule

// File: tb/tb_cond_flags_unit.sv
// Scoreboard bench for cond_flags_unit: two instances share one stimulus
// stream (A: LAT=1 with bypass, B: LAT=3 register-only), expected results are
// queued at issue and retired by a negedge monitor.
module tb_cond_flags_unit;

    localparam int LANES = 2;
    localparam int NBANK = 4;
    localparam int IDXW  = 2;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int EK_ADV   = 0;
    localparam int EK_STALL = 1;
    localparam int EK_RST   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [3:0]          flag_we, flag_wdata;
    logic                save_en, restore_en;
    logic [IDXW-1:0]     save_idx, restore_idx;
    logic [LANES-1:0]    in_valid;
    logic [4*LANES-1:0]  in_cond;
    logic                stall;

    logic [LANES-1:0] a_valid, a_pass, a_nv, b_valid, b_pass, b_nv;
    logic [3:0]       a_flags, b_flags;

    cond_flags_unit #(.LANES(LANES), .NBANK(NBANK), .LAT(LAT_A), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .flag_we(flag_we), .flag_wdata(flag_wdata),
        .save_en(save_en), .save_idx(save_idx), .restore_en(restore_en),
        .restore_idx(restore_idx), .in_valid(in_valid), .in_cond(in_cond),
        .stall(stall), .out_valid(a_valid), .out_pass(a_pass), .out_nv(a_nv),
        .flags(a_flags)
    );

    cond_flags_unit #(.LANES(LANES), .NBANK(NBANK), .LAT(LAT_B), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .flag_we(flag_we), .flag_wdata(flag_wdata),
        .save_en(save_en), .save_idx(save_idx), .restore_en(restore_en),
        .restore_idx(restore_idx), .in_valid(in_valid), .in_cond(in_cond),
        .stall(stall), .out_valid(b_valid), .out_pass(b_pass), .out_nv(b_nv),
        .flags(b_flags)
    );

    typedef struct packed {
        logic [31:0] tag;
        logic [1:0]  v;
        logic [1:0]  p;
        logic [1:0]  n;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t cur_a, cur_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   adv_cnt  = 0;
    int   edge_kind = EK_RST;
    bit   mon_en   = 1'b0;

    logic [3:0] m_flags;
    logic [3:0] m_bank [NBANK];

    // Hand-derived truth masks: bit f is the pass result for flags f={N,Z,C,V}.
    function automatic logic [15:0] pass_mask(input logic [3:0] c);
        case (c)
            4'h0: return 16'hF0F0;
            4'h1: return 16'h0F0F;
            4'h2: return 16'hCCCC;
            4'h3: return 16'h3333;
            4'h4: return 16'hFF00;
            4'h5: return 16'h00FF;
            4'h6: return 16'hAAAA;
            4'h7: return 16'h5555;
            4'h8: return 16'h0C0C;
            4'h9: return 16'hF3F3;
            4'hA: return 16'hAA55;
            4'hB: return 16'h55AA;
            4'hC: return 16'h0A05;
            4'hD: return 16'hF5FA;
            4'hE: return 16'hFFFF;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic exp_t build(input logic [3:0] f, input int tag);
        exp_t e;
        logic [3:0]  c;
        logic [15:0] m;
        e     = '0;
        e.tag = 32'(tag);
        for (int l = 0; l < LANES; l++) begin
            c      = in_cond[4*l +: 4];
            m      = pass_mask(c);
            e.v[l] = in_valid[l];
            e.p[l] = in_valid[l] & m[f];
            e.n[l] = in_valid[l] & (c == 4'hF);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: queue expected results, then advance the model.
    task automatic step();
        logic [3:0] base, nxt;
        base = restore_en ? m_bank[restore_idx] : m_flags;
        nxt  = (base & ~flag_we) | (flag_wdata & flag_we);
        if (!rst && !stall && in_valid != '0) begin
            qa.push_back(build(nxt, adv_cnt + 1));
            qb.push_back(build(m_flags, adv_cnt + 1));
        end
        @(posedge clk);
        if (rst) begin
            m_flags = '0;
            for (int i = 0; i < NBANK; i++) m_bank[i] = '0;
            qa.delete();
            qb.delete();
            edge_kind = EK_RST;
        end else begin
            if (save_en) m_bank[save_idx] = m_flags;
            m_flags = nxt;
            if (stall) begin
                edge_kind = EK_STALL;
            end else begin
                adv_cnt++;
                edge_kind = EK_ADV;
            end
        end
        #1;
    endtask

    task automatic idle();
        flag_we     = '0;
        flag_wdata  = '0;
        save_en     = 1'b0;
        save_idx    = '0;
        restore_en  = 1'b0;
        restore_idx = '0;
        in_valid    = '0;
        in_cond     = '0;
        stall       = 1'b0;
    endtask

    task automatic set_lanes(input logic v0, input logic [3:0] c0,
                             input logic v1, input logic [3:0] c1);
        in_valid = {v1, v0};
        in_cond  = {c1, c0};
    endtask

    task automatic mon_one(input int d, input int lat, input logic [1:0] ov,
                           input logic [1:0] op, input logic [1:0] onv);
        exp_t  e, cur;
        int    qsz;
        string nm;
        nm  = (d == 0) ? "A" : "B";
        cur = (d == 0) ? cur_a : cur_b;
        qsz = (d == 0) ? qa.size() : qb.size();
        if (edge_kind == EK_RST) begin
            chk({nm, "_rst_clear"}, {26'd0, ov, op, onv}, 32'd0);
            cur = '0;
        end else if (edge_kind == EK_STALL) begin
            chk({nm, "_stall_frozen"}, {26'd0, ov, op, onv}, {26'd0, cur.v, cur.p, cur.n});
        end else if (ov != '0) begin
            if (qsz == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_unexpected: got valid=%b pass=%b nv=%b, expected no result", nm, ov, op, onv);
                cur = '0;
            end else begin
                e = (d == 0) ? qa.pop_front() : qb.pop_front();
                chk({nm, "_latency"}, 32'(adv_cnt), e.tag + 32'(lat - 1));
                chk({nm, "_result"}, {26'd0, ov, op, onv}, {26'd0, e.v, e.p, e.n});
                $display("%s result tag=%0d valid=%b pass=%b nv=%b", nm, e.tag, ov, op, onv);
                cur = e;
            end
        end else begin
            cur = '0;
            if (qsz != 0) begin
                e = (d == 0) ? qa[0] : qb[0];
                if (e.tag + 32'(lat - 1) <= 32'(adv_cnt)) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s_missing: got no result, expected tag=%0d valid=%b pass=%b", nm, e.tag, e.v, e.p);
                    if (d == 0) void'(qa.pop_front());
                    else        void'(qb.pop_front());
                end
            end
        end
        if (d == 0) cur_a = cur;
        else        cur_b = cur;
    endtask

    // Monitor: retire or verify outputs half a cycle after each edge.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_one(0, LAT_A, a_valid, a_pass, a_nv);
            mon_one(1, LAT_B, b_valid, b_pass, b_nv);
            chk("A_flags", {28'd0, a_flags}, {28'd0, m_flags});
            chk("B_flags", {28'd0, b_flags}, {28'd0, m_flags});
        end
    end

    initial begin
        cur_a   = '0;
        cur_b   = '0;
        m_flags = '0;
        for (int i = 0; i < NBANK; i++) m_bank[i] = '0;
        idle();
        rst = 1'b1;
        step();
        mon_en = 1'b1;
        step();
        rst = 1'b0;

        // Masked full write, then EQ/NE against Z=1
        flag_we = 4'hF; flag_wdata = 4'b0100;
        step();
        idle();
        set_lanes(1'b1, 4'h0, 1'b1, 4'h1);
        step();
        idle();
        step();

        // Sweep every condition code across every flag value
        for (int f = 0; f < 16; f++) begin
            idle();
            flag_we = 4'hF; flag_wdata = 4'(f);
            step();
            for (int c = 0; c < 16; c += 2) begin
                idle();
                set_lanes(1'b1, 4'(c), 1'b1, 4'(c + 1));
                step();
            end
        end
        idle();
        set_lanes(1'b0, 4'hE, 1'b1, 4'hF);
        step();

        // Same-cycle bypass: A sees the new Z, B sees the old one
        idle();
        flag_we = 4'hF; flag_wdata = 4'h0;
        step();
        idle();
        flag_we = 4'b0100; flag_wdata = 4'b0100;
        set_lanes(1'b1, 4'h0, 1'b1, 4'h1);
        step();

        // Banks: save 1010 to slot 2, restore with a V write, save+restore collision
        idle();
        flag_we = 4'hF; flag_wdata = 4'b1010;
        step();
        idle();
        save_en = 1'b1; save_idx = 2'd2;
        step();
        idle();
        flag_we = 4'hF; flag_wdata = 4'b0000;
        step();
        idle();
        restore_en = 1'b1; restore_idx = 2'd2;
        flag_we = 4'b0001; flag_wdata = 4'b0001;
        set_lanes(1'b1, 4'hB, 1'b1, 4'h4);
        step();
        idle();
        flag_we = 4'hF; flag_wdata = 4'b0110;
        step();
        idle();
        save_en = 1'b1; save_idx = 2'd2;
        restore_en = 1'b1; restore_idx = 2'd2;
        step();
        idle();
        restore_en = 1'b1; restore_idx = 2'd2;
        set_lanes(1'b1, 4'h0, 1'b1, 4'h2);
        step();
        idle();
        restore_en = 1'b1; restore_idx = 2'd3;
        flag_we = 4'b1000; flag_wdata = 4'b1000;
        step();

        // Stall mid-flight; writeback continues, stalled inputs ignored
        idle();
        set_lanes(1'b1, 4'hE, 1'b1, 4'hF);
        step();
        idle();
        stall = 1'b1;
        flag_we = 4'hF; flag_wdata = 4'b0011;
        set_lanes(1'b1, 4'h0, 1'b1, 4'h0);
        step();
        idle();
        stall = 1'b1;
        set_lanes(1'b1, 4'h1, 1'b1, 4'hE);
        step();
        idle();
        repeat (4) step();

        // Reset with results in flight; banks must come back as zero
        idle();
        set_lanes(1'b1, 4'hE, 1'b0, 4'h0);
        step();
        set_lanes(1'b1, 4'h1, 1'b1, 4'hE);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        restore_en = 1'b1; restore_idx = 2'd2;
        step();
        idle();
        set_lanes(1'b1, 4'h0, 1'b1, 4'h3);
        step();
        idle();
        repeat (5) step();

        chk("A_queue_drained", 32'(qa.size()), 32'd0);
        chk("B_queue_drained", 32'(qb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
